// File: rtl/auto_script_engine_if.sv
// Signal bundle between the auto-mode script engine, the script ROM,
// the game-client feedback and the UART command path.
interface auto_script_engine_if #(
  parameter int unsigned PC_W = 8
);
  logic            en;
  logic            go;
  logic            sweep_en;
  logic [15:0]     script;
  logic [7:0]      fb;
  logic [PC_W-1:0] pc;
  logic [7:0]      cmd;
  logic            busy;
  logic            done;
  logic            err;
  logic [PC_W-1:0] err_pc;
  logic [4:0]      state_o;

  modport master (output en, go, sweep_en, script, fb,
                  input  pc, cmd, busy, done, err, err_pc, state_o);
  modport slave  (input  en, go, sweep_en, script, fb,
                  output pc, cmd, busy, done, err, err_pc, state_o);
endinterface

// File: rtl/auto_script_engine.sv
// Auto-mode script executor: fetches instructions by pc, issues kitchen
// command bytes and paces itself on client feedback with timeout/retry.
module auto_script_engine #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned PC_STEP     = 2,
  parameter int unsigned WAIT_DIV    = 1,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned RETRIES     = 2,
  parameter int unsigned SWEEP_FIRST = 7,
  parameter int unsigned SWEEP_LAST  = 20,
  parameter logic [5:0]  BIN_ID      = 6'd21
) (
  input  logic                clk,
  input  logic                rst,
  auto_script_engine_if.slave bus
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned DW = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
  localparam int unsigned RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [DW-1:0]   DIV_LAST  = DW'(WAIT_DIV - 1);
  localparam logic [RW-1:0]   RETRY_MAX = RW'(RETRIES);
  localparam logic [PC_W-1:0] PC_INC    = PC_W'(PC_STEP);
  localparam logic [5:0]      SW_FIRST  = 6'(SWEEP_FIRST);
  localparam logic [5:0]      SW_LAST   = 6'(SWEEP_LAST);

  localparam logic [7:0] CMD_NONE = 8'h00, CMD_START = 8'h01, CMD_END = 8'h02,
                         CMD_GET = 8'h04, CMD_PUT = 8'h08, CMD_INTERACT = 8'h10,
                         CMD_MOVE = 8'h20, CMD_THROW = 8'h40;

  typedef enum logic [4:0] {
    S_IDLE = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_START = 5'd3,
    S_SEL = 5'd4, S_MOVE = 5'd5, S_GET = 5'd6, S_PUT = 5'd7, S_INTER = 5'd8,
    S_THROW = 5'd9, S_BIN_SEL = 5'd10, S_BIN_THROW = 5'd11, S_WAIT = 5'd12,
    S_WAIT_ARR = 5'd13, S_WAIT_RDY = 5'd14, S_SW_SEL = 5'd15, S_SW_CHK = 5'd16,
    S_SW_MOVE = 5'd17, S_SW_GET = 5'd18, S_SW_BIN = 5'd19, S_SW_THROW = 5'd20,
    S_NEXT = 5'd21, S_END = 5'd22, S_DONE = 5'd23, S_ERROR = 5'd24
  } state_t;

  state_t          state_q, state_d, retry_st;
  logic [PC_W-1:0] pc_q, pc_d, err_pc_q, err_pc_d;
  logic [7:0]      cmd_q, cmd_d, arg_q, arg_d, units_q, units_d;
  logic [1:0]      act_q, act_d;
  logic [5:0]      tgt_q, tgt_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            to_hit, to_fire, restart;
  logic [7:0]      op;
  logic [7:0]      fb;
  logic            unused_fb;

  assign op        = bus.script[7:0];
  assign fb        = bus.fb;
  assign unused_fb = ^{fb[7:6], fb[1:0]};
  assign to_hit    = (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_pc_d = err_pc_q;
    arg_d    = arg_q;
    act_d    = act_q;
    tgt_d    = tgt_q;
    div_d    = div_q;
    units_d  = units_q;
    retry_d  = retry_q;
    to_fire  = 1'b0;
    retry_st = S_IDLE;
    restart  = 1'b0;
    cmd_d    = CMD_NONE;

    case (state_q)
      S_IDLE:   if (bus.go) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        arg_d   = bus.script[15:8];
        act_d   = op[4:3];
        div_d   = '0;
        units_d = '0;
        if      (op[4:0] == 5'b10100) state_d = S_END;
        else if (op[4:0] == 5'b01100) state_d = S_START;
        else if (op[4:0] == 5'b11100) begin
          pc_d    = PC_W'(bus.script[15:8]);
          retry_d = '0;
          state_d = S_FETCH;
        end
        else if (op[2:0] == 3'b001)   state_d = S_SEL;
        else if (op[4:0] == 5'b00011) state_d = S_WAIT;
        else if (op == 8'h0B)         state_d = S_WAIT_ARR;
        else if (op == 8'h4B)         state_d = S_WAIT_RDY;
        else begin
          state_d  = S_ERROR;
          err_pc_d = pc_q;
        end
      end
      S_START: begin
        cmd_d = CMD_START;
        if (fb[5:2] != 4'd0) state_d = bus.sweep_en ? S_SW_SEL : S_NEXT;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_START; end
      end
      S_SEL: begin
        cmd_d   = {arg_q[5:0], 2'b11};
        state_d = (act_q == 2'b11) ? S_THROW : S_MOVE;
      end
      S_MOVE: begin
        cmd_d = CMD_MOVE;
        if (fb[2]) begin
          // Arriving for a GET while already holding: dump it in the bin first.
          if (act_q == 2'b00 && fb[3]) state_d = S_BIN_SEL;
          else if (act_q == 2'b00)     state_d = S_GET;
          else if (act_q == 2'b01)     state_d = S_PUT;
          else                         state_d = S_INTER;
        end
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SEL; end
      end
      S_GET: begin
        cmd_d = CMD_GET;
        if (fb[3]) state_d = S_NEXT;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SEL; end
      end
      S_PUT: begin
        cmd_d = CMD_PUT;
        if (!fb[3]) state_d = S_NEXT;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SEL; end
      end
      S_INTER: begin
        cmd_d   = CMD_INTERACT;
        state_d = S_NEXT;
      end
      S_THROW: begin
        cmd_d = CMD_THROW;
        if (!fb[3]) state_d = S_NEXT;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SEL; end
      end
      S_BIN_SEL: begin
        cmd_d   = {BIN_ID, 2'b11};
        state_d = S_BIN_THROW;
      end
      S_BIN_THROW: begin
        cmd_d = CMD_THROW;
        if (!fb[3]) state_d = S_SEL;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SEL; end
      end
      S_WAIT: begin
        // Operand 0 still costs one cycle; otherwise operand*WAIT_DIV cycles.
        if (arg_q == 8'd0) state_d = S_NEXT;
        else if (div_q == DIV_LAST) begin
          div_d   = '0;
          units_d = units_q + 8'd1;
          if (units_q + 8'd1 == arg_q) state_d = S_NEXT;
        end
        else div_d = div_q + 1'b1;
      end
      S_WAIT_ARR: begin
        cmd_d = CMD_INTERACT;
        if (fb[2]) state_d = S_NEXT;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_WAIT_ARR; end
      end
      S_WAIT_RDY: begin
        cmd_d = CMD_INTERACT;
        if (fb[4]) state_d = S_NEXT;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_WAIT_RDY; end
      end
      S_SW_SEL: begin
        cmd_d   = {tgt_q, 2'b11};
        state_d = S_SW_CHK;
      end
      S_SW_CHK: begin
        if (fb[5]) state_d = S_SW_MOVE;
        else if (tgt_q == SW_LAST) begin
          tgt_d   = SW_FIRST;
          state_d = S_NEXT;
        end
        else begin
          tgt_d   = tgt_q + 6'd1;
          state_d = S_SW_SEL;
        end
      end
      S_SW_MOVE: begin
        cmd_d = CMD_MOVE;
        if (fb[2]) state_d = S_SW_GET;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SW_SEL; end
      end
      S_SW_GET: begin
        cmd_d = CMD_GET;
        if (fb[3]) state_d = S_SW_BIN;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SW_SEL; end
      end
      S_SW_BIN: begin
        cmd_d   = {BIN_ID, 2'b11};
        state_d = S_SW_THROW;
      end
      S_SW_THROW: begin
        cmd_d = CMD_THROW;
        if (!fb[3]) state_d = S_SW_SEL;
        else if (to_hit) begin to_fire = 1'b1; retry_st = S_SW_SEL; end
      end
      S_NEXT: begin
        pc_d    = pc_q + PC_INC;
        retry_d = '0;
        state_d = S_FETCH;
      end
      S_END: begin
        cmd_d   = CMD_END;
        state_d = S_DONE;
      end
      S_DONE, S_ERROR: ;
      default: state_d = S_IDLE;
    endcase

    if (to_fire) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = retry_st;
        restart = 1'b1;
      end
      else begin
        state_d  = S_ERROR;
        err_pc_d = pc_q;
      end
    end
    if (state_d == S_ERROR) cmd_d = CMD_NONE;
    cnt_d = (state_d != state_q || restart) ? '0 : cnt_q + 1'b1;
  end

  // en low freezes every register, command byte included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      err_pc_q <= '0;
      cmd_q    <= CMD_NONE;
      arg_q    <= '0;
      act_q    <= '0;
      tgt_q    <= SW_FIRST;
      cnt_q    <= '0;
      div_q    <= '0;
      units_q  <= '0;
      retry_q  <= '0;
    end
    else if (bus.en) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_pc_q <= err_pc_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      act_q    <= act_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      units_q  <= units_d;
      retry_q  <= retry_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.cmd     = cmd_q;
  assign bus.err_pc  = err_pc_q;
  assign bus.state_o = state_q;
  assign bus.busy    = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign bus.done    = (state_q == S_DONE);
  assign bus.err     = (state_q == S_ERROR);
endmodule

// File: tb/tb_auto_script_engine.sv
// Directed bench for auto_script_engine: scripted ROM, feedback driven in
// reaction to the observed command byte, command/pc change logs.
module tb_auto_script_engine;
  localparam logic [4:0] S_IDLE = 5'd0, S_MOVE = 5'd5, S_WAIT = 5'd12,
                         S_DONE = 5'd23, S_ERROR = 5'd24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] rom [0:255];
  logic [7:0]  cmd_log [$];
  logic [7:0]  pc_log [$];
  logic [7:0]  last_cmd = 8'h00;
  logic [7:0]  last_pc = 8'h00;
  int          wait_cyc = 0;
  int          move_cyc = 0;

  auto_script_engine_if #(.PC_W(8)) bus ();

  auto_script_engine #(
    .PC_W(8), .PC_STEP(2), .WAIT_DIV(3), .TIMEOUT_CYC(16), .RETRIES(1),
    .SWEEP_FIRST(7), .SWEEP_LAST(9), .BIN_ID(6'd21)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered ROM: script is valid one cycle after pc changes.
  always @(posedge clk) bus.script <= rom[bus.pc];

  always @(negedge clk) begin
    if (bus.cmd !== last_cmd) begin
      last_cmd <= bus.cmd;
      if (bus.cmd != 8'h00) cmd_log.push_back(bus.cmd);
    end
    if (bus.pc !== last_pc) begin
      last_pc <= bus.pc;
      pc_log.push_back(bus.pc);
    end
    if (bus.state_o == S_WAIT) wait_cyc <= wait_cyc + 1;
    if (bus.state_o == S_MOVE) move_cyc <= move_cyc + 1;
  end

  function automatic string fmt_q(input logic [7:0] q[$], input int base);
    string s = "";
    for (int i = base; i < q.size(); i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit seq_ok(input logic [7:0] q[$], input int base, input logic [7:0] e[$]);
    if (q.size() - base != e.size()) return 1'b0;
    for (int i = 0; i < e.size(); i++) if (q[base+i] !== e[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.go = 1'b0; bus.en = 1'b1; bus.sweep_en = 1'b0; bus.fb = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 16'h00FF;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_cmd(input logic [7:0] v, input string nm);
    int n = 0;
    while (bus.cmd !== v && n < 200) begin @(negedge clk); n++; end
    if (bus.cmd !== v) begin
      checks++; failures++;
      $display("FAIL %s timeout: cmd=%02h required=%02h", nm, bus.cmd, v);
    end
  endtask

  task automatic wait_state(input logic [4:0] s, input string nm);
    int n = 0;
    while (bus.state_o !== s && n < 300) begin @(negedge clk); n++; end
    if (bus.state_o !== s) begin
      checks++; failures++;
      $display("FAIL %s timeout: state=%0d required=%0d", nm, bus.state_o, s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.go = 1'b0; bus.en = 1'b1; bus.sweep_en = 1'b0; bus.fb = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 16'h00FF;
    tick(2);
    checks++; if (bus.state_o !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d req=0", bus.state_o); end
    checks++; if (bus.pc !== 8'd0) begin failures++; $display("FAIL rst_pc got=%0d req=0", bus.pc); end
    checks++; if (bus.cmd !== 8'h00) begin failures++; $display("FAIL rst_cmd got=%02h req=00", bus.cmd); end
    checks++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      failures++; $display("FAIL rst_flags busy/done/err got=%b req=000", {bus.busy, bus.done, bus.err}); end
    checks++; if (bus.err_pc !== 8'd0) begin failures++; $display("FAIL rst_err_pc got=%0d req=0", bus.err_pc); end
    rst = 1'b0;
    tick(3);
    checks++; if (bus.state_o !== S_IDLE) begin failures++; $display("FAIL idle_no_go got=%0d req=0", bus.state_o); end
  endtask

  task automatic test_basic();
    int cb, pb;
    logic [7:0] exp[$];
    logic [7:0] exp_pc[$];
    do_reset();
    rom[0] = 16'h000C; rom[2] = 16'h0901; rom[4] = 16'h0014;
    cb = cmd_log.size(); pb = pc_log.size();
    bus.go = 1'b1;
    wait_cmd(8'h01, "t1_start"); tick(3); bus.fb = 8'h20;
    wait_cmd(8'h27, "t1_sel");   bus.fb = 8'h00;
    wait_cmd(8'h20, "t1_move");  tick(4); bus.fb = 8'h04;
    wait_cmd(8'h04, "t1_get");   tick(2); bus.fb = 8'h0C;
    wait_state(S_DONE, "t1_done");
    tick(2);
    exp = '{8'h01, 8'h27, 8'h20, 8'h04, 8'h02};
    exp_pc = '{8'd2, 8'd4};
    checks++; if (!seq_ok(cmd_log, cb, exp)) begin failures++;
      $display("FAIL t1_cmd_seq got=%s req=%s", fmt_q(cmd_log, cb), fmt_q(exp, 0)); end
    checks++; if (!seq_ok(pc_log, pb, exp_pc)) begin failures++;
      $display("FAIL t1_pc_seq got=%s req=%s", fmt_q(pc_log, pb), fmt_q(exp_pc, 0)); end
    checks++; if ({bus.done, bus.busy, bus.err} !== 3'b100) begin failures++;
      $display("FAIL t1_done done/busy/err got=%b req=100", {bus.done, bus.busy, bus.err}); end
  endtask

  task automatic test_wait();
    int cb, w0;
    logic [7:0] exp[$];
    do_reset();
    rom[0] = 16'h0503; rom[2] = 16'h0014;
    cb = cmd_log.size(); w0 = wait_cyc;
    bus.go = 1'b1;
    wait_state(S_DONE, "t2_done");
    tick(2);
    exp = '{8'h02};
    checks++; if (wait_cyc - w0 != 15) begin failures++;
      $display("FAIL t2_wait_cycles got=%0d req=15", wait_cyc - w0); end
    checks++; if (!seq_ok(cmd_log, cb, exp)) begin failures++;
      $display("FAIL t2_cmd_seq got=%s req=%s", fmt_q(cmd_log, cb), fmt_q(exp, 0)); end
    checks++; if (bus.pc !== 8'd2) begin failures++; $display("FAIL t2_pc got=%0d req=2", bus.pc); end
  endtask

  task automatic test_get_holding();
    int cb;
    logic [7:0] exp[$];
    do_reset();
    rom[0] = 16'h0901; rom[2] = 16'h0014;
    cb = cmd_log.size();
    bus.go = 1'b1;
    wait_cmd(8'h20, "t3_move");  bus.fb = 8'h0C;
    wait_cmd(8'h40, "t3_throw"); bus.fb = 8'h04;
    wait_cmd(8'h04, "t3_get");   bus.fb = 8'h0C;
    wait_state(S_DONE, "t3_done");
    tick(2);
    exp = '{8'h27, 8'h20, 8'h57, 8'h40, 8'h27, 8'h20, 8'h04, 8'h02};
    checks++; if (!seq_ok(cmd_log, cb, exp)) begin failures++;
      $display("FAIL t3_cmd_seq got=%s req=%s", fmt_q(cmd_log, cb), fmt_q(exp, 0)); end
  endtask

  task automatic test_sweep();
    int cb;
    logic [7:0] exp[$];
    do_reset();
    rom[0] = 16'h000C; rom[2] = 16'h0014;
    cb = cmd_log.size();
    bus.sweep_en = 1'b1; bus.go = 1'b1;
    wait_cmd(8'h01, "t4_start"); bus.fb = 8'h10;
    wait_cmd(8'h1F, "t4_sel7");  bus.fb = 8'h00;
    wait_cmd(8'h23, "t4_sel8");  bus.fb = 8'h20;
    wait_cmd(8'h20, "t4_move");  bus.fb = 8'h04;
    wait_cmd(8'h04, "t4_get");   bus.fb = 8'h0C;
    wait_cmd(8'h40, "t4_throw"); bus.fb = 8'h00;
    wait_state(S_DONE, "t4_done");
    tick(2);
    exp = '{8'h01, 8'h1F, 8'h23, 8'h20, 8'h04, 8'h57, 8'h40, 8'h23, 8'h27, 8'h02};
    checks++; if (!seq_ok(cmd_log, cb, exp)) begin failures++;
      $display("FAIL t4_cmd_seq got=%s req=%s", fmt_q(cmd_log, cb), fmt_q(exp, 0)); end
    checks++; if (bus.pc !== 8'd2) begin failures++; $display("FAIL t4_pc got=%0d req=2", bus.pc); end
  endtask

  task automatic test_timeout();
    int cb, m0;
    logic [7:0] exp[$];
    do_reset();
    rom[0] = 16'h0103; rom[2] = 16'h0103; rom[4] = 16'h0103; rom[6] = 16'h0909;
    cb = cmd_log.size(); m0 = move_cyc;
    bus.go = 1'b1;
    wait_state(S_ERROR, "t5_error");
    tick(2);
    exp = '{8'h27, 8'h20, 8'h27, 8'h20};
    checks++; if (!seq_ok(cmd_log, cb, exp)) begin failures++;
      $display("FAIL t5_cmd_seq got=%s req=%s", fmt_q(cmd_log, cb), fmt_q(exp, 0)); end
    checks++; if (move_cyc - m0 != 32) begin failures++;
      $display("FAIL t5_move_cycles got=%0d req=32", move_cyc - m0); end
    checks++; if (bus.err !== 1'b1 || bus.err_pc !== 8'd6) begin failures++;
      $display("FAIL t5_err err=%b err_pc=%0d req err=1 err_pc=6", bus.err, bus.err_pc); end
    checks++; if (bus.cmd !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL t5_idle_out cmd=%02h busy=%b done=%b req 00/0/0", bus.cmd, bus.busy, bus.done); end
  endtask

  task automatic test_illegal_jump();
    do_reset();
    rom[0] = 16'h101C; rom[16] = 16'h00FF;
    bus.go = 1'b1;
    wait_state(S_ERROR, "t_ill_error");
    tick(1);
    checks++; if (bus.err !== 1'b1 || bus.err_pc !== 8'h10) begin failures++;
      $display("FAIL ill_err err=%b err_pc=%02h req err=1 err_pc=10", bus.err, bus.err_pc); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    rom[0] = 16'h0103; rom[2] = 16'h0901;
    bus.go = 1'b1;
    wait_cmd(8'h20, "t6_move");
    checks++; if (bus.pc !== 8'd2 || bus.busy !== 1'b1) begin failures++;
      $display("FAIL rst_mid_pre pc=%0d busy=%b req pc=2 busy=1", bus.pc, bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.state_o !== S_IDLE || bus.pc !== 8'd0) begin failures++;
      $display("FAIL rst_mid_state state=%0d pc=%0d req 0/0", bus.state_o, bus.pc); end
    checks++; if (bus.cmd !== 8'h00 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL rst_mid_out cmd=%02h busy=%b req 00/0", bus.cmd, bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    bus.go = 1'b0;
  endtask

  task automatic test_enable_jump();
    int w0, n;
    do_reset();
    rom[0] = 16'h0503; rom[2] = 16'h001C;
    bus.en = 1'b0; bus.go = 1'b1;
    tick(3);
    checks++; if (bus.state_o !== S_IDLE) begin failures++;
      $display("FAIL en_go_ignored state=%0d req=0", bus.state_o); end
    w0 = wait_cyc;
    bus.en = 1'b1;
    wait_state(S_WAIT, "t6_wait");
    tick(3);
    bus.en = 1'b0;
    tick(10);
    checks++; if (bus.state_o !== S_WAIT || bus.pc !== 8'd0) begin failures++;
      $display("FAIL en_frozen state=%0d pc=%0d req state=12 pc=0", bus.state_o, bus.pc); end
    bus.en = 1'b1;
    n = 0;
    while (bus.pc !== 8'd2 && n < 100) begin @(negedge clk); n++; end
    checks++; if (wait_cyc - w0 != 25) begin failures++;
      $display("FAIL en_wait_cycles got=%0d req=25", wait_cyc - w0); end
    n = 0;
    while (bus.pc !== 8'd0 && n < 50) begin @(negedge clk); n++; end
    checks++; if (bus.pc !== 8'd0 || bus.err !== 1'b0) begin failures++;
      $display("FAIL jump_pc pc=%0d err=%b req pc=0 err=0", bus.pc, bus.err); end
  endtask

  initial begin
    bus.go = 1'b0; bus.en = 1'b1; bus.sweep_en = 1'b0; bus.fb = 8'h00;
    test_reset();
    test_basic();
    test_wait();
    test_get_holding();
    test_sweep();
    test_timeout();
    test_illegal_jump();
    test_rst_mid();
    test_enable_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
